// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core load/store path and a
// debug/loader port using a 3-state FSM with round-robin priority and debug lock.
`default_nettype none

module dmem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [DATA_W-1:0] core_wdata_i,
   output logic              core_ack_o,
   output logic [DATA_W-1:0] core_rdata_o,
   output logic              core_stall_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   input  logic              dbg_lock_i,
   output logic              dbg_ack_o,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_DBG  = 1'b1;

   logic [1:0]        state_q,      state_d;
   logic              owner_q,      owner_d;
   logic              last_owner_q, last_owner_d;
   logic              we_q,         we_d;
   logic [ADDR_W-1:0] addr_q,       addr_d;
   logic [DATA_W-1:0] wdata_q,      wdata_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q,  dbg_rdata_d;
   logic              grant_dbg;

   // Debug wins when alone, when the core had the last turn, or when it holds the lock.
   assign grant_dbg = dbg_req_i &
                      (~core_req_i | (last_owner_q == OWN_CORE) | dbg_lock_i);

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      core_rdata_d = core_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (core_req_i || dbg_req_i) begin
               owner_d = grant_dbg ? OWN_DBG : OWN_CORE;
               we_d    = grant_dbg ? dbg_we_i    : core_we_i;
               addr_d  = grant_dbg ? dbg_addr_i  : core_addr_i;
               wdata_d = grant_dbg ? dbg_wdata_i : core_wdata_i;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // Read data lands straight in the owner's output register.
            if (!we_q) begin
               if (owner_q == OWN_DBG) dbg_rdata_d  = mem_rdata_i;
               else                    core_rdata_d = mem_rdata_i;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            last_owner_d = owner_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_CORE;
         last_owner_q <= OWN_DBG;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         core_rdata_q <= core_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   assign core_ack_o   = (state_q == S_RESP) && (owner_q == OWN_CORE);
   assign dbg_ack_o    = (state_q == S_RESP) && (owner_q == OWN_DBG);
   assign core_stall_o = core_req_i & ~core_ack_o;
   assign core_rdata_o = core_rdata_q;
   assign dbg_rdata_o  = dbg_rdata_q;
   assign mem_read_o   = (state_q == S_ACCESS) && !we_q;
   assign mem_write_o  = (state_q == S_ACCESS) && we_q;
   assign mem_addr_o   = addr_q;
   assign mem_wdata_o  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, corner-case sequences and a randomized run
// against a transaction-level arbitration model for dmem_arbiter.
`default_nettype none

module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_req, core_we, core_ack, core_stall;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic        dbg_req, dbg_we, dbg_lock, dbg_ack;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   int n_checks = 0;
   int n_fail   = 0;
   int q_kind[$];
   int q_at[$];

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:0]];

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
      .core_wdata_i(core_wdata), .core_ack_o(core_ack), .core_rdata_o(core_rdata),
      .core_stall_o(core_stall),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
      .dbg_wdata_i(dbg_wdata), .dbg_lock_i(dbg_lock), .dbg_ack_o(dbg_ack),
      .dbg_rdata_o(dbg_rdata),
      .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   typedef struct {
      logic        creq, dreq, lock;
      logic        cwe;
      logic [31:0] caddr, cwdata;
      logic        dwe;
      logic [31:0] daddr, dwdata;
      logic        exp_dbg;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // The memory commits a write on the edge that ends the write cycle.
   task automatic tick();
      if (mem_write) mem[mem_addr[7:0]] = mem_wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
      dbg_lock = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " core_ack"},   32'(core_ack),  32'd0);
      chk({tag, " dbg_ack"},    32'(dbg_ack),   32'd0);
      chk({tag, " mem_read"},   32'(mem_read),  32'd0);
      chk({tag, " mem_write"},  32'(mem_write), 32'd0);
      chk({tag, " mem_addr"},   mem_addr,       32'd0);
      chk({tag, " mem_wdata"},  mem_wdata,      32'd0);
      chk({tag, " core_rdata"}, core_rdata,     32'd0);
      chk({tag, " dbg_rdata"},  dbg_rdata,      32'd0);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk_zero("reset");
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Records every ack over n cycles: kind 0 = core, 1 = debug.
   task automatic collect(input int n);
      q_kind.delete();
      q_at.delete();
      for (int k = 0; k < n; k++) begin
         tick();
         if (core_ack) begin q_kind.push_back(0); q_at.push_back(k); end
         if (dbg_ack)  begin q_kind.push_back(1); q_at.push_back(k); end
      end
   endtask

   initial begin
      int free_at, ack_at, last, w, a;
      logic exp_we;
      logic [31:0] exp_rdata;

      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
      mem[8'h10] = 32'hDEAD_BEEF;

      vt[0] = '{1'b1,1'b0,1'b0, 1'b0,32'h10,32'h0,        1'b0,32'h0, 32'h0,        1'b0,32'hDEAD_BEEF};
      vt[1] = '{1'b1,1'b0,1'b0, 1'b1,32'h20,32'h1234_5678, 1'b0,32'h0, 32'h0,        1'b0,32'h0};
      vt[2] = '{1'b1,1'b0,1'b0, 1'b0,32'h20,32'h0,        1'b0,32'h0, 32'h0,        1'b0,32'h1234_5678};
      vt[3] = '{1'b1,1'b1,1'b0, 1'b0,32'h31,32'h0,        1'b0,32'h30,32'h0,        1'b1,32'hA000_0030};
      vt[4] = '{1'b1,1'b1,1'b0, 1'b0,32'h31,32'h0,        1'b0,32'h30,32'h0,        1'b0,32'hA000_0031};
      vt[5] = '{1'b0,1'b1,1'b1, 1'b0,32'h0, 32'h0,        1'b1,32'h40,32'hCAFE_F00D,1'b1,32'h0};
      vt[6] = '{1'b1,1'b1,1'b1, 1'b0,32'h31,32'h0,        1'b0,32'h40,32'h0,        1'b1,32'hCAFE_F00D};
      vt[7] = '{1'b1,1'b1,1'b1, 1'b0,32'h31,32'h0,        1'b0,32'h41,32'h0,        1'b1,32'hA000_0041};
      vt[8] = '{1'b1,1'b1,1'b0, 1'b0,32'h31,32'h0,        1'b0,32'h41,32'h0,        1'b0,32'hA000_0031};

      // ---------------- vector table ----------------
      do_reset();
      for (int i = 0; i < 9; i++) begin
         logic        wwe;
         logic [31:0] waddr, wwdata;
         core_req = vt[i].creq; core_we = vt[i].cwe; core_addr = vt[i].caddr; core_wdata = vt[i].cwdata;
         dbg_req  = vt[i].dreq; dbg_we  = vt[i].dwe; dbg_addr  = vt[i].daddr; dbg_wdata  = vt[i].dwdata;
         dbg_lock = vt[i].lock;
         wwe    = vt[i].exp_dbg ? vt[i].dwe    : vt[i].cwe;
         waddr  = vt[i].exp_dbg ? vt[i].daddr  : vt[i].caddr;
         wwdata = vt[i].exp_dbg ? vt[i].dwdata : vt[i].cwdata;
         tick();
         chk($sformatf("vec%0d access mem_read", i),  32'(mem_read),  32'(!wwe));
         chk($sformatf("vec%0d access mem_write", i), 32'(mem_write), 32'(wwe));
         chk($sformatf("vec%0d access mem_addr", i),  mem_addr,       waddr);
         if (wwe) chk($sformatf("vec%0d access mem_wdata", i), mem_wdata, wwdata);
         chk($sformatf("vec%0d access stall", i), 32'(core_stall), 32'(vt[i].creq));
         chk($sformatf("vec%0d access acks", i),  32'({core_ack, dbg_ack}), 32'd0);
         tick();
         chk($sformatf("vec%0d core_ack", i), 32'(core_ack), 32'(!vt[i].exp_dbg));
         chk($sformatf("vec%0d dbg_ack", i),  32'(dbg_ack),  32'(vt[i].exp_dbg));
         chk($sformatf("vec%0d resp mem rw", i), 32'({mem_read, mem_write}), 32'd0);
         chk($sformatf("vec%0d resp stall", i), 32'(core_stall), 32'(vt[i].creq & vt[i].exp_dbg));
         if (!wwe) chk($sformatf("vec%0d rdata", i),
                       vt[i].exp_dbg ? dbg_rdata : core_rdata, vt[i].exp_rdata);
         idle_inputs();
         tick();
      end

      // ---------------- alternation from reset, unlocked ----------------
      do_reset();
      core_req = 1'b1; core_addr = 32'h10;
      dbg_req  = 1'b1; dbg_addr  = 32'h30;
      collect(12);
      chk("alt ack count", 32'(q_kind.size()), 32'd4);
      if (q_kind.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("alt order %0d", i), 32'(q_kind[i]), 32'(i % 2));
            chk($sformatf("alt time %0d", i),  32'(q_at[i]),   32'(1 + 3 * i));
         end
      end

      // ---------------- debug lock: debug keeps the memory ----------------
      dbg_lock = 1'b1;
      collect(12);
      chk("lock ack count", 32'(q_kind.size()), 32'd4);
      foreach (q_kind[i]) chk($sformatf("lock owner %0d", i), 32'(q_kind[i]), 32'd1);
      dbg_lock = 1'b0;
      collect(3);
      chk("unlock ack count", 32'(q_kind.size()), 32'd1);
      if (q_kind.size() > 0) chk("unlock first owner", 32'(q_kind[0]), 32'd0);

      // ---------------- reset during a debug read access ----------------
      do_reset();
      dbg_req = 1'b1; dbg_addr = 32'h30;
      tick();
      chk("abort pre mem_read", 32'(mem_read), 32'd1);
      rst_n = 1'b0;
      core_req = 1'b1; core_addr = 32'h10;
      #1;
      chk_zero("abort");
      tick();
      chk("abort held acks", 32'({core_ack, dbg_ack}), 32'd0);
      rst_n = 1'b1;
      collect(3);
      chk("abort ack count", 32'(q_kind.size()), 32'd1);
      if (q_kind.size() > 0) chk("abort first owner", 32'(q_kind[0]), 32'd0);
      chk("abort core_rdata", core_rdata, 32'hDEAD_BEEF);
      chk("abort dbg_rdata held", dbg_rdata, 32'd0);

      // ---------------- core drops req during ACCESS ----------------
      do_reset();
      core_req = 1'b1; core_addr = 32'h20;
      tick();
      core_req = 1'b0;
      tick();
      chk("drop core_ack", 32'(core_ack), 32'd1);
      chk("drop core_rdata", core_rdata, 32'h1234_5678);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("drop quiet %0d", k), 32'({core_ack, dbg_ack, mem_read, mem_write}), 32'd0);
      end

      // ---------------- randomized run vs transaction model ----------------
      do_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      free_at = 0; ack_at = -1; last = 1; w = 0; exp_we = 1'b0; exp_rdata = '0;
      for (int e = 0; e < 900; e++) begin
         if (!core_req && ($urandom % 2 == 0)) begin
            core_req = 1'b1; core_we = 1'($urandom % 2);
            core_addr = 32'($urandom_range(0, 63)); core_wdata = $urandom;
         end
         if (!dbg_req && ($urandom % 2 == 0)) begin
            dbg_req = 1'b1; dbg_we = 1'($urandom % 2);
            dbg_addr = 32'($urandom_range(0, 63)); dbg_wdata = $urandom;
         end
         dbg_lock = ($urandom % 4 == 0);
         if (e >= free_at && (core_req || dbg_req)) begin
            if (core_req && dbg_req) w = (last == 1 && dbg_lock) ? 1 : 1 - last;
            else                     w = dbg_req ? 1 : 0;
            last    = w;
            free_at = e + 3;
            ack_at  = e + 1;
            exp_we  = (w == 1) ? dbg_we : core_we;
            a       = int'(((w == 1) ? dbg_addr : core_addr) & 32'hFF);
            if (exp_we) ref_mem[a] = (w == 1) ? dbg_wdata : core_wdata;
            else        exp_rdata  = ref_mem[a];
         end
         tick();
         chk("rnd core_ack", 32'(core_ack), 32'(ack_at == e && w == 0));
         chk("rnd dbg_ack",  32'(dbg_ack),  32'(ack_at == e && w == 1));
         chk("rnd stall",    32'(core_stall), 32'(core_req & ~core_ack));
         if (ack_at == e && !exp_we)
            chk("rnd rdata", (w == 1) ? dbg_rdata : core_rdata, exp_rdata);
         if (core_ack) core_req = 1'b0;
         if (dbg_ack)  dbg_req  = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
